// File: rtl/aespim_gmul_unit.sv
// Iterative 32x32 carry-less multiplier with reduction modulo x^32+x^7+x^2+x+1.
// Define AESPIM_GMUL_ACC_EN to add the GHASH-style accumulator (acc_clr_i / acc_o).
module aespim_gmul_unit #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_o,
`ifdef AESPIM_GMUL_ACC_EN
    input  logic        acc_clr_i,
    output logic [31:0] acc_o,
`endif
    output logic        busy_o
);

    localparam int         MUL_CYCLES = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT   = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] BPC5       = 5'(BITS_PER_CYCLE);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
            $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_FOLD1,
        ST_FOLD2,
        ST_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod_q;
    logic [39:0] t_q;
    logic [4:0]  cnt_q;
    logic [31:0] res_q;
    logic [31:0] a_in;
    logic [63:0] mul_prod;
    logic [4:0]  bit_idx;
    logic [39:0] fold1;
    logic [31:0] fold2;
    logic        accept;

`ifdef AESPIM_GMUL_ACC_EN
    logic [31:0] acc_q;
    assign a_in  = acc_clr_i ? op_a_i : (op_a_i ^ acc_q);
    assign acc_o = acc_q;
`else
    assign a_in = op_a_i;
`endif

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = (state_q == ST_DONE);
    assign res_o       = res_q;
    assign accept      = (state_q == ST_IDLE) && req_valid_i && !flush_i;

    // Partial products for the B multiplier bits consumed this cycle
    always_comb begin
        mul_prod = prod_q;
        bit_idx  = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            bit_idx = cnt_q * BPC5 + 5'(k);
            if (b_q[bit_idx]) begin
                mul_prod = mul_prod ^ ({32'b0, a_q} << bit_idx);
            end
        end
    end

    // First fold: high word times 0x87 lands in at most 39 bits
    always_comb begin
        fold1 = {8'b0, prod_q[31:0]};
        for (int i = 0; i < 32; i++) begin
            if (prod_q[32 + i]) begin
                fold1 = fold1 ^ (40'h87 << i);
            end
        end
    end

    // Second fold: the 8 spill bits fold back below degree 32
    always_comb begin
        fold2 = t_q[31:0];
        for (int j = 0; j < 8; j++) begin
            if (t_q[32 + j]) begin
                fold2 = fold2 ^ (32'h87 << j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (req_valid_i) state_d = ST_MUL;
                ST_MUL:   if (cnt_q == LAST_CNT) state_d = ST_FOLD1;
                ST_FOLD1: state_d = ST_FOLD2;
                ST_FOLD2: state_d = ST_DONE;
                ST_DONE:  if (res_ready_i) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers freeze on flush so an aborted op leaves no side effects
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (!flush_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q    <= a_in;
                        b_q    <= op_b_i;
                        prod_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                ST_MUL: begin
                    prod_q <= mul_prod;
                    cnt_q  <= cnt_q + 5'd1;
                end
                ST_FOLD1: t_q   <= fold1;
                ST_FOLD2: res_q <= fold2;
                default: ;
            endcase
        end
    end

`ifdef AESPIM_GMUL_ACC_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (!flush_i && state_q == ST_FOLD2) begin
            acc_q <= fold2;
        end
    end
`endif

endmodule

// File: tb/tb_aespim_gmul_unit.sv
// Scoreboard bench for aespim_gmul_unit (default BITS_PER_CYCLE=4); build with
// AESPIM_GMUL_ACC_EN defined to also exercise the accumulator.
module tb_aespim_gmul_unit;

    localparam int LAT = 32 / 4 + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_o;
    logic        busy;
`ifdef AESPIM_GMUL_ACC_EN
    logic        acc_clr;
    logic [31:0] acc_o;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    aespim_gmul_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .flush_i     (flush),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res_o),
`ifdef AESPIM_GMUL_ACC_EN
        .acc_clr_i   (acc_clr),
        .acc_o       (acc_o),
`endif
        .busy_o      (busy)
    );

    // Reference: plain carry-less product, then long division by the field polynomial
    function automatic logic [31:0] gf_model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) if (b[i]) p = p ^ (64'(a) << i);
        for (int i = 63; i >= 32; i--) if (p[i]) p = p ^ (64'h1_0000_0087 << (i - 32));
        return p[31:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        flush = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected,
                          output logic [31:0] res, output int lat, output bit ok);
        int wait_cnt;
        ok = 1'b1;
        lat = 0;
        res = '0;
        wait_cnt = 0;
        exp_q.push_back(expected);
        req_valid = 1'b1;
        op_a = a;
        op_b = b;
        while (!req_ready && wait_cnt < 50) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (!req_ready) begin
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = res_valid;
        res = res_o;
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_res_o: got %h want 0", res_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
`ifdef AESPIM_GMUL_ACC_EN
        checks++; if (acc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_acc: got %h want 0", acc_o); end
`endif
    endtask

    task automatic test_basic();
        logic [31:0] ta [6] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'h3};
        logic [31:0] tb [6] = '{32'h1, 32'h2, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h5};
        logic [31:0] te [6] = '{32'h1, 32'h87, 32'h5555_402F, 32'h0, 32'h0, 32'hF};
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], te[i], res, lat, ok);
            exp_v = exp_q.pop_front();
            checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_timeout[%0d]: res_valid=%b want 1", i, res_valid); end
            checks++; if (lat !== LAT) begin failures++; $display("[TB] FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++; if (res !== exp_v) begin failures++; $display("[TB] FAIL basic_result[%0d]: got %h want %h", i, res, exp_v); end
            accept_result();
            checks++; if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_drop[%0d]: got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [31:0] exp_v;
        logic [31:0] held;
        int lat;
        bit ok;
        run_op(32'h0000_0006, 32'h0000_0003, 32'h0000_000A, res, lat, ok);
        held = res_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (res_valid !== 1'b1 || res_o !== held) begin failures++; $display("[TB] FAIL hold_stable[%0d]: valid=%b res=%h want 1/%h", i, res_valid, res_o, held); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        exp_v = exp_q.pop_front();
        checks++; if (!ok || res !== exp_v) begin failures++; $display("[TB] FAIL hold_result: got %h ok=%b want %h", res, ok, exp_v); end
        accept_result();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %b want 1", req_ready); end
        run_op(32'h0000_0002, 32'h0000_0003, 32'h0000_0006, res, lat, ok);
        exp_v = exp_q.pop_front();
        checks++; if (!ok || lat !== LAT) begin failures++; $display("[TB] FAIL b2b_latency: got %0d ok=%b want %0d", lat, ok, LAT); end
        checks++; if (res !== exp_v) begin failures++; $display("[TB] FAIL b2b_result: got %h want %h", res, exp_v); end
        accept_result();
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [31:0] exp_v;
        logic [31:0] kept;
        int lat;
        bit ok;
        bit seen;
        // Flush in MUL cycle 3
        exp_q.push_back(gf_model(32'h5, 32'h7));
        req_valid = 1'b1;
        op_a = 32'h5;
        op_b = 32'h7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(exp_q.pop_front());
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_mul_idle: busy=%b ready=%b want 0/1", busy, req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (res_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_valid: got %b want 0", seen); end
        // Flush in IDLE blocks a concurrent request
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_reject: busy=%b want 0", busy); end
        run_op(32'h3, 32'h3, 32'h5, res, lat, ok);
        exp_v = exp_q.pop_front();
        checks++; if (!ok || res !== exp_v) begin failures++; $display("[TB] FAIL flush_after: got %h ok=%b want %h", res, ok, exp_v); end
        kept = res;
        // Flush together with res_ready in DONE drops the result
        flush = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_done: valid=%b busy=%b want 0/0", res_valid, busy); end
        checks++; if (res_o !== kept) begin failures++; $display("[TB] FAIL flush_done_res_hold: got %h want %h", res_o, kept); end
    endtask

    task automatic test_reset_mid_op();
        exp_q.push_back(gf_model(32'h1234, 32'h5678));
        req_valid = 1'b1;
        op_a = 32'h1234;
        op_b = 32'h5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_state: busy=%b valid=%b want 0/0", busy, res_valid); end
        checks++; if (res_o !== 32'h0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_outputs: res=%h ready=%b want 0/1", res_o, req_ready); end
`ifdef AESPIM_GMUL_ACC_EN
        checks++; if (acc_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_acc: got %h want 0", acc_o); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(a, b, gf_model(a, b), res, lat, ok);
            exp_v = exp_q.pop_front();
            checks++; if (!ok || res !== exp_v) begin failures++; $display("[TB] FAIL random[%0d]: a=%h b=%h got %h want %h", i, a, b, res, exp_v); end
            accept_result();
        end
    endtask

`ifdef AESPIM_GMUL_ACC_EN
    task automatic test_acc();
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        bit ok;
        acc_clr = 1'b1;
        run_op(32'h2, 32'h3, 32'h6, res, lat, ok);
        exp_v = exp_q.pop_front();
        checks++; if (!ok || res !== exp_v) begin failures++; $display("[TB] FAIL acc_first: got %h want %h", res, exp_v); end
        accept_result();
        acc_clr = 1'b0;
        run_op(32'h1, 32'h1, 32'h7, res, lat, ok);
        exp_v = exp_q.pop_front();
        checks++; if (!ok || res !== exp_v) begin failures++; $display("[TB] FAIL acc_chain: got %h want %h", res, exp_v); end
        checks++; if (acc_o !== 32'h7) begin failures++; $display("[TB] FAIL acc_value: got %h want 7", acc_o); end
        accept_result();
        acc_clr = 1'b1;
        test_reset_mid_op();
    endtask
`endif

    initial begin
`ifdef AESPIM_GMUL_ACC_EN
        acc_clr = 1'b1;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        test_random();
`ifdef AESPIM_GMUL_ACC_EN
        test_acc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
